sp_tile_mem_sequencer: RTL and testbench

- Sequences one scratchpad tile transfer (load or store) as ROWS back-to-back row transactions on the scratchpad port of the main-memory arbiter.
- Sits between scratchpad control and the memory arbiter. It owns the row counter, address generation and the wait handshake, so the arbiter handles only single-row transactions.

---
 rtl/sp_tile_mem_sequencer_if.sv | 33 +++
 rtl/sp_tile_mem_sequencer.sv | 138 +++++++++++++
 tb/tb_sp_tile_mem_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sp_tile_mem_sequencer_if.sv
// Row-transaction bus between the tile sequencer and the main-memory arbiter.
//   master : sequencer side (drives request, direction, address, write data)
//   slave  : arbiter side (drives wait and read data)
// A transaction completes in any cycle with mem_req & !mem_wait.
interface sp_tile_mem_sequencer_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
);
    logic              mem_req;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wait;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_wen,
        output mem_addr,
        output mem_wdata,
        input  mem_wait,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_wen,
        input  mem_addr,
        input  mem_wdata,
        output mem_wait,
        output mem_rdata
    );
endinterface

// File: rtl/sp_tile_mem_sequencer.sv
// Scratchpad tile transfer sequencer. Breaks one tile load/store into ROWS
// back-to-back single-row transactions toward the memory arbiter.
// Ports:
//   CLK, nRST          clock, asynchronous active-low reset
//   sp_load_req        tile load request (level, held until sp_ack)
//   sp_store_req       tile store request (level, held until sp_ack)
//   sp_addr            tile base byte address, sampled on accept
//   sp_ack             request accepted (combinational, idle only)
//   st_row / st_data   row index of requested store data / its row data
//   ld_valid           one-cycle pulse qualifying ld_row / ld_data
//   done               one-cycle pulse at end of a tile transfer
//   busy               high whenever not idle
//   mem                row-transaction bus to the arbiter (master side)
module sp_tile_mem_sequencer #(
    parameter int unsigned ROWS      = 4,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned ROW_BYTES = 8
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     sp_load_req,
    input  logic                     sp_store_req,
    input  logic [ADDR_W-1:0]        sp_addr,
    output logic                     sp_ack,
    output logic [$clog2(ROWS)-1:0]  st_row,
    input  logic [DATA_W-1:0]        st_data,
    output logic                     ld_valid,
    output logic [$clog2(ROWS)-1:0]  ld_row,
    output logic [DATA_W-1:0]        ld_data,
    output logic                     done,
    output logic                     busy,
    sp_tile_mem_sequencer_if.master  mem
);

    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam int unsigned OFF_W = $clog2(ROW_BYTES);
    localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(ROW_BYTES - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StStore, StDone} state_e;

    state_e            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              ld_valid_q, ld_valid_d;
    logic [ROW_W-1:0]  ld_row_q, ld_row_d;
    logic [DATA_W-1:0] ld_data_q, ld_data_d;
    logic [ADDR_W-1:0] row_addr;

    // Wraps modulo 2^ADDR_W by construction of the adder width.
    assign row_addr = base_q + (ADDR_W'(row_q) << OFF_W);

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        base_d        = base_q;
        ld_valid_d    = 1'b0;
        ld_row_d      = ld_row_q;
        ld_data_d     = ld_data_q;
        sp_ack        = 1'b0;
        done          = 1'b0;
        busy          = (state_q != StIdle);
        mem.mem_req   = 1'b0;
        mem.mem_wen   = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;

        unique case (state_q)
            StIdle: begin
                if (sp_load_req || sp_store_req) begin
                    sp_ack  = 1'b1;
                    base_d  = sp_addr & ALIGN_MASK;
                    row_d   = '0;
                    // Load wins a tie; the store stays pending on its level request.
                    state_d = sp_load_req ? StLoad : StStore;
                end
            end
            StLoad: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = row_addr;
                if (!mem.mem_wait) begin
                    ld_valid_d = 1'b1;
                    ld_row_d   = row_q;
                    ld_data_d  = mem.mem_rdata;
                    if (row_q == LAST_ROW) begin
                        state_d = StDone;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            StStore: begin
                mem.mem_req   = 1'b1;
                mem.mem_wen   = 1'b1;
                mem.mem_addr  = row_addr;
                mem.mem_wdata = st_data;
                if (!mem.mem_wait) begin
                    if (row_q == LAST_ROW) begin
                        state_d = StDone;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= StIdle;
            row_q      <= '0;
            base_q     <= '0;
            ld_valid_q <= 1'b0;
            ld_row_q   <= '0;
            ld_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            base_q     <= base_d;
            ld_valid_q <= ld_valid_d;
            ld_row_q   <= ld_row_d;
            ld_data_q  <= ld_data_d;
        end
    end

    // Store data is read combinationally from the scratchpad at the current row.
    assign st_row   = row_q;
    assign ld_valid = ld_valid_q;
    assign ld_row   = ld_row_q;
    assign ld_data  = ld_data_q;

endmodule

// File: tb/tb_sp_tile_mem_sequencer.sv
// Scoreboard bench for sp_tile_mem_sequencer: stimulus pushes expected row
// transactions, load beats and done pulses; a negedge monitor pops and compares.
module tb_sp_tile_mem_sequencer;

    logic        CLK;
    logic        nRST;
    logic        sp_load_req;
    logic        sp_store_req;
    logic [31:0] sp_addr;
    logic        sp_ack;
    logic [1:0]  st_row;
    logic [63:0] st_data;
    logic        ld_valid;
    logic [1:0]  ld_row;
    logic [63:0] ld_data;
    logic        done;
    logic        busy;
    logic [63:0] st_mem [4];

    sp_tile_mem_sequencer_if #(.ADDR_W(32), .DATA_W(64)) mem_if ();

    sp_tile_mem_sequencer #(
        .ROWS(4), .DATA_W(64), .ADDR_W(32), .ROW_BYTES(8)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .sp_load_req(sp_load_req),
        .sp_store_req(sp_store_req),
        .sp_addr(sp_addr),
        .sp_ack(sp_ack),
        .st_row(st_row),
        .st_data(st_data),
        .ld_valid(ld_valid),
        .ld_row(ld_row),
        .ld_data(ld_data),
        .done(done),
        .busy(busy),
        .mem(mem_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Arbiter model: read data tagged with the address and 0xA0 + row-in-32B.
    assign mem_if.mem_rdata = {mem_if.mem_addr, 24'h0, 8'hA0 + {6'b0, mem_if.mem_addr[4:3]}};
    assign st_data = st_mem[st_row];

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [63:0] wdata;
    } mem_t;
    typedef struct packed {
        logic [1:0]  row;
        logic [63:0] data;
    } ld_t;

    mem_t exp_mem [$];
    ld_t  exp_ld [$];
    bit   exp_done [$];
    int   n_chk = 0;
    int   n_pass = 0;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic logic [63:0] exp_rd(input logic [31:0] a);
        return {a, 24'h0, 8'hA0 + {6'b0, a[4:3]}};
    endfunction

    task automatic push_tile(input logic wen, input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] a2, input logic [31:0] a3);
        logic [31:0] a [4];
        a = '{a0, a1, a2, a3};
        for (int r = 0; r < 4; r++) begin
            exp_mem.push_back('{wen: wen, addr: a[r], wdata: st_mem[r]});
            if (!wen) exp_ld.push_back('{row: 2'(r), data: exp_rd(a[r])});
        end
        exp_done.push_back(1'b1);
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ack(input string name);
        int n;
        n = 0;
        @(negedge CLK);
        while (!sp_ack && n < 40) begin
            @(negedge CLK);
            n++;
        end
        chk(name, 64'(n < 40), 64'd1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge CLK);
        while (busy && n < 40) begin
            @(negedge CLK);
            n++;
        end
        chk(name, 64'(n < 40), 64'd1);
    endtask

    task automatic check_idle(input string name);
        chk({name, ".busy"}, busy, 0);
        chk({name, ".done"}, done, 0);
        chk({name, ".sp_ack"}, sp_ack, 0);
        chk({name, ".mem_req"}, mem_if.mem_req, 0);
        chk({name, ".mem_wen"}, mem_if.mem_wen, 0);
        chk({name, ".mem_addr"}, mem_if.mem_addr, 0);
        chk({name, ".mem_wdata"}, mem_if.mem_wdata, 0);
        chk({name, ".ld_valid"}, ld_valid, 0);
        chk({name, ".ld_row"}, ld_row, 0);
        chk({name, ".ld_data"}, ld_data, 0);
        chk({name, ".st_row"}, st_row, 0);
    endtask

    // Monitor: compares whatever the DUT presents this cycle against the queues.
    initial begin
        mem_t m;
        ld_t  l;
        forever begin
            @(negedge CLK);
            if (nRST === 1'b1) begin
                if (busy) chk("ack_while_busy", sp_ack, 0);
                if (mem_if.mem_req && !mem_if.mem_wait) begin
                    chk("mem_txn_expected", 64'(exp_mem.size() > 0), 64'd1);
                    if (exp_mem.size() > 0) begin
                        m = exp_mem.pop_front();
                        chk("mem_wen", mem_if.mem_wen, m.wen);
                        chk("mem_addr", mem_if.mem_addr, m.addr);
                        if (m.wen) chk("mem_wdata", mem_if.mem_wdata, m.wdata);
                    end
                end
                if (ld_valid) begin
                    chk("ld_expected", 64'(exp_ld.size() > 0), 64'd1);
                    if (exp_ld.size() > 0) begin
                        l = exp_ld.pop_front();
                        chk("ld_row", ld_row, l.row);
                        chk("ld_data", ld_data, l.data);
                    end
                end
                if (done) begin
                    chk("done_expected", 64'(exp_done.size() > 0), 64'd1);
                    if (exp_done.size() > 0) void'(exp_done.pop_front());
                end
            end
        end
    end

    initial begin
        logic [1:0] st_seq [6];
        st_seq = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3};
        st_mem = '{64'h1111_2222_3333_0000, 64'h4444_5555_6666_0001,
                   64'h7777_8888_9999_0002, 64'hAAAA_BBBB_CCCC_0003};
        nRST = 1'b0;
        sp_load_req = 1'b0;
        sp_store_req = 1'b0;
        sp_addr = 32'h0;
        mem_if.mem_wait = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_idle("reset");
        cyc();
        nRST = 1'b1;

        // Load, no stall, cycle-exact; a store request pulsed mid-load is ignored.
        push_tile(1'b0, 32'h1000, 32'h1008, 32'h1010, 32'h1018);
        cyc();
        sp_load_req = 1'b1;
        sp_addr = 32'h0000_1000;
        for (int c = 0; c < 7; c++) begin
            if (c == 1) sp_load_req = 1'b0;
            sp_store_req = (c == 2);
            @(negedge CLK);
            chk($sformatf("ld.ack c%0d", c), sp_ack, 64'(c == 0));
            chk($sformatf("ld.busy c%0d", c), busy, 64'(c >= 1 && c <= 5));
            chk($sformatf("ld.req c%0d", c), mem_if.mem_req, 64'(c >= 1 && c <= 4));
            chk($sformatf("ld.valid c%0d", c), ld_valid, 64'(c >= 2 && c <= 5));
            chk($sformatf("ld.done c%0d", c), done, 64'(c == 5));
            cyc();
        end

        // Store with two wait cycles on row 1.
        push_tile(1'b1, 32'h1000, 32'h1008, 32'h1010, 32'h1018);
        sp_store_req = 1'b1;
        sp_addr = 32'h0000_1000;
        for (int c = 0; c < 9; c++) begin
            if (c == 1) sp_store_req = 1'b0;
            mem_if.mem_wait = (c == 2 || c == 3);
            @(negedge CLK);
            if (c >= 1 && c <= 6) chk($sformatf("st.row c%0d", c), st_row, st_seq[c-1]);
            if (c >= 2 && c <= 4) begin
                chk($sformatf("st.hold_addr c%0d", c), mem_if.mem_addr, 32'h1008);
                chk($sformatf("st.hold_wdata c%0d", c), mem_if.mem_wdata, st_mem[1]);
                chk($sformatf("st.hold_wen c%0d", c), mem_if.mem_wen, 1);
            end
            chk($sformatf("st.done c%0d", c), done, 64'(c == 7));
            cyc();
        end
        mem_if.mem_wait = 1'b0;

        // Simultaneous requests: load first, then the held store with its own address.
        push_tile(1'b0, 32'h2000, 32'h2008, 32'h2010, 32'h2018);
        push_tile(1'b1, 32'h3000, 32'h3008, 32'h3010, 32'h3018);
        sp_load_req = 1'b1;
        sp_store_req = 1'b1;
        sp_addr = 32'h0000_2000;
        wait_ack("both.ack_load");
        cyc();
        sp_load_req = 1'b0;
        sp_addr = 32'h0000_3000;
        wait_ack("both.ack_store");
        cyc();
        sp_store_req = 1'b0;
        wait_idle("both.idle");
        cyc();

        // Unaligned base near the top of the address space wraps to zero.
        push_tile(1'b0, 32'hFFFF_FFF0, 32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_0008);
        sp_load_req = 1'b1;
        sp_addr = 32'hFFFF_FFF5;
        wait_ack("wrap.ack");
        cyc();
        sp_load_req = 1'b0;
        wait_idle("wrap.idle");
        cyc();

        // Reset after row 1 of a load completes: rows 0,1 issue, only row 0 returns.
        exp_mem.push_back('{wen: 1'b0, addr: 32'h4000, wdata: 64'h0});
        exp_mem.push_back('{wen: 1'b0, addr: 32'h4008, wdata: 64'h0});
        exp_ld.push_back('{row: 2'd0, data: exp_rd(32'h4000)});
        sp_load_req = 1'b1;
        sp_addr = 32'h0000_4000;
        @(negedge CLK);
        chk("rst.ack", sp_ack, 1);
        cyc();
        sp_load_req = 1'b0;
        cyc();
        cyc();
        nRST = 1'b0;
        @(negedge CLK);
        check_idle("rst_mid");
        cyc();
        nRST = 1'b1;
        push_tile(1'b0, 32'h5000, 32'h5008, 32'h5010, 32'h5018);
        sp_load_req = 1'b1;
        sp_addr = 32'h0000_5000;
        wait_ack("after_rst.ack");
        cyc();
        sp_load_req = 1'b0;
        wait_idle("after_rst.idle");
        repeat (3) cyc();

        chk("mem_queue_drained", exp_mem.size(), 0);
        chk("ld_queue_drained", exp_ld.size(), 0);
        chk("done_queue_drained", exp_done.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
